// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register busy scoreboard (issue claims, writeback clears).
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [DEPTH-1:0]           busy_vec,
    output logic [ADDR_W:0]            busy_count
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (ADDR_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Next state: writes (highest port wins) clear busy, a claim on the same edge re-sets it.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    regs_d[r] = wr_data[j*DATA_W +: DATA_W];
                    busy_d[r] = 1'b0;
                end else begin
                    regs_d[r] = regs_d[r];
                end
            end
            if (claim_en && (claim_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else begin
                busy_d[r] = busy_d[r];
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end else begin
            regs_d[0] = regs_d[0];
        end
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_d[r] = '0;
            end
            busy_d = '0;
        end else begin
            busy_d = busy_d;
        end
        busy_count_d = popcount(busy_d);
    end

    // State registers; busy_count tracks busy_vec after the same edge.
    always_ff @(posedge clk) begin
        regs_q       <= regs_d;
        busy_q       <= busy_d;
        busy_count_q <= busy_count_d;
    end

    // Combinational read ports.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy[i]                  = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            // Forward in-flight write data; suppressed under reset so reads stay zero.
            for (int j = 0; j < NUM_WR; j++) begin
                if (!reset && wr_en[j]
                    && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])
                    && !((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    rd_busy[i] = claim_en && (claim_addr == rd_addr[i*ADDR_W +: ADDR_W]);
                end else begin
                    rd_busy[i] = rd_busy[i];
                end
            end
`endif
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations for same-cycle reads adapt when REGFILE_BYPASS_EN is defined.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;
    localparam int ADDR_W = 4;

    logic                     clk;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [DEPTH-1:0]         busy_vec;
    logic [ADDR_W:0]          busy_count;

    int checks;
    int errors;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic set_wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]                    = 1'b1;
        wr_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        wr_data[port*DATA_W +: DATA_W] = data;
    endtask

    function automatic logic [63:0] rdata(input int port);
        return {32'h0, rd_data[port*DATA_W +: DATA_W]};
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;

        // 1: reset held, every address on every port reads zero / not busy
        tick();
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, a);
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                chk($sformatf("reset_data_a%0d_p%0d", a, p), rdata(p), 64'h0);
                chk($sformatf("reset_busy_a%0d_p%0d", a, p), {63'h0, rd_busy[p]}, 64'h0);
            end
        end
        chk("reset_busy_vec", {48'h0, busy_vec}, 64'h0);
        chk("reset_busy_count", {59'h0, busy_count}, 64'h0);
        reset = 1'b0;

        // 2: claim r5, then write it back
        claim_en = 1'b1; claim_addr = 4'd5;
        tick();
        claim_en = 1'b0;
        set_rd(0, 5);
        #1;
        chk("claim5_rd_busy0", {63'h0, rd_busy[0]}, 64'h1);
        chk("claim5_busy_vec", {48'h0, busy_vec}, 64'h0020);
        chk("claim5_busy_count", {59'h0, busy_count}, 64'h1);
        set_wr(0, 5, 32'hDEAD_BEEF);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr5_same_cycle_data", rdata(0), 64'hDEAD_BEEF);
        chk("wr5_same_cycle_busy", {63'h0, rd_busy[0]}, 64'h0);
`else
        chk("wr5_same_cycle_data", rdata(0), 64'h0);
        chk("wr5_same_cycle_busy", {63'h0, rd_busy[0]}, 64'h1);
`endif
        tick();
        wr_en = '0;
        #1;
        chk("wr5_data", rdata(0), 64'hDEAD_BEEF);
        chk("wr5_busy0", {63'h0, rd_busy[0]}, 64'h0);
        chk("wr5_busy_count", {59'h0, busy_count}, 64'h0);

        // 3a: same-address collision, port 1 wins; write to non-busy register
        set_wr(0, 3, 32'h11);
        set_wr(1, 3, 32'h22);
        tick();
        wr_en = '0;
        set_rd(1, 3);
        #1;
        chk("collide_r3_data", rdata(1), 64'h22);
        chk("collide_r3_busy", {63'h0, rd_busy[1]}, 64'h0);

        // 3b: claim and write of r7 on the same edge, claim wins
        claim_en = 1'b1; claim_addr = 4'd7;
        set_wr(0, 7, 32'h5);
        tick();
        claim_en = 1'b0; wr_en = '0;
        set_rd(2, 7);
        #1;
        chk("claimwr_r7_data", rdata(2), 64'h5);
        chk("claimwr_r7_busy", {63'h0, rd_busy[2]}, 64'h1);
        chk("claimwr_busy_vec", {48'h0, busy_vec}, 64'h0080);
        chk("claimwr_busy_count", {59'h0, busy_count}, 64'h1);

        // 3c: re-claim a busy register, then unclaimed write clears it
        claim_en = 1'b1; claim_addr = 4'd7;
        tick();
        claim_en = 1'b0;
        #1;
        chk("reclaim_busy_count", {59'h0, busy_count}, 64'h1);
        set_wr(1, 7, 32'h6);
        tick();
        wr_en = '0;
        #1;
        chk("wr7_data", rdata(2), 64'h6);
        chk("wr7_busy", {63'h0, rd_busy[2]}, 64'h0);
        chk("wr7_busy_count", {59'h0, busy_count}, 64'h0);

        // 4: register 0 ignores claims and writes
        claim_en = 1'b1; claim_addr = 4'd0;
        set_wr(0, 0, 32'hFFFF_FFFF);
        set_wr(1, 0, 32'hFFFF_FFFF);
        set_rd(0, 0);
        #1;
        chk("r0_same_cycle_data", rdata(0), 64'h0);
        tick();
        claim_en = 1'b0; wr_en = '0;
        #1;
        chk("r0_data", rdata(0), 64'h0);
        chk("r0_busy", {63'h0, rd_busy[0]}, 64'h0);
        chk("r0_busy_count", {59'h0, busy_count}, 64'h0);

        // 5: claims r1..r15 with a reset at r8 (overriding a claim and a write)
        for (int r = 1; r <= 7; r++) begin
            claim_en = 1'b1; claim_addr = ADDR_W'(r);
            tick();
        end
        claim_en = 1'b0;
        #1;
        chk("claims1_7_busy_vec", {48'h0, busy_vec}, 64'h00FE);
        chk("claims1_7_busy_count", {59'h0, busy_count}, 64'h7);
        reset = 1'b1;
        claim_en = 1'b1; claim_addr = 4'd8;
        set_wr(0, 3, 32'hCAFE);
        tick();
        reset = 1'b0; claim_en = 1'b0; wr_en = '0;
        #1;
        chk("midreset_busy_vec", {48'h0, busy_vec}, 64'h0);
        chk("midreset_busy_count", {59'h0, busy_count}, 64'h0);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(1, a);
            #1;
            chk($sformatf("midreset_data_a%0d", a), rdata(1), 64'h0);
        end
        for (int r = 9; r <= 15; r++) begin
            claim_en = 1'b1; claim_addr = ADDR_W'(r);
            tick();
        end
        claim_en = 1'b0;
        #1;
        chk("claims9_15_busy_vec", {48'h0, busy_vec}, 64'hFE00);
        chk("claims9_15_busy_count", {59'h0, busy_count}, 64'h7);

        // 6: read-during-write of r9 (busy) on port 2
        set_rd(2, 9);
        set_wr(0, 9, 32'h1234);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_r9_same_data", rdata(2), 64'h1234);
        chk("rdw_r9_same_busy", {63'h0, rd_busy[2]}, 64'h0);
`else
        chk("rdw_r9_same_data", rdata(2), 64'h0);
        chk("rdw_r9_same_busy", {63'h0, rd_busy[2]}, 64'h1);
`endif
        tick();
        wr_en = '0;
        #1;
        chk("rdw_r9_next_data", rdata(2), 64'h1234);
        chk("rdw_r9_next_busy", {63'h0, rd_busy[2]}, 64'h0);
        chk("rdw_busy_vec", {48'h0, busy_vec}, 64'hFC00);
        chk("rdw_busy_count", {59'h0, busy_count}, 64'h6);

        // 6b: read-during-collision on r11, port 1 data is the winner
        set_rd(0, 11);
        set_wr(0, 11, 32'hAA);
        set_wr(1, 11, 32'hBB);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_collide_same", rdata(0), 64'hBB);
`else
        chk("rdw_collide_same", rdata(0), 64'h0);
`endif
        tick();
        wr_en = '0;
        #1;
        chk("rdw_collide_next", rdata(0), 64'hBB);
        chk("rdw_collide_count", {59'h0, busy_count}, 64'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
